tmds_decoder_dvi: RTL and testbench
===================================

Name: tmds_decoder_dvi

Overview:
- Receive-side counterpart of the DVI TMDS transmit chain: accepts 10-bit parallel TMDS words from an external deserializer (one channel) in the recovered pixel-clock domain.
- Finds character alignment by hunting for control-token runs during blanking, requesting bit-slips from the deserializer until aligned.
- Decodes aligned symbols back to 8-bit pixel data or a 2-bit control value.
- One instance per TMDS channel; the three instances feed a downstream sync/pixel recovery block.

Parameters:
- CTRL_RUN, 8, consecutive control tokens required to declare lock.
- SEARCH_TIMEOUT, 2048, cycles in SEARCH without lock before a bit-slip is requested.
- SLIP_WAIT, 16, cycles ignored after a bit-slip while the deserializer settles.
- LOSS_TIMEOUT, 4096, cycles in LOCKED without any control token before lock is dropped.

Ports:
- i_clk  in  1  pixel clock; the only clock in the block.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_tmds  in  10  raw parallel TMDS word from the deserializer; bit 0 is first on the wire.
- o_bitslip  out  1  one-cycle pulse requesting the deserializer shift its word boundary by one bit.
- o_locked  out  1  character alignment established.
- o_de  out  1  data enable; high when the current output is a decoded data symbol and o_locked=1.
- o_data  out  8  decoded pixel byte.
- o_ctrl  out  2  decoded control value {C1,C0}; holds its last value during data.

Behaviour:
- Reset (async assert, sync release): o_bitslip=0, o_locked=0, o_de=0, o_data=0, o_ctrl=0, all counters 0, FSM in SEARCH.
- Pipeline:
  - Stage 1 registers i_tmds into sym.
  - Stage 2 registers the decode results.
  - Latency is 2 cycles from i_tmds to o_data/o_ctrl/o_de.
  - The FSM observes sym (stage 1).
- Control tokens (bits 9:0):
  - 1101010100 = 00
  - 0010101011 = 01
  - 0101010100 = 10
  - 1010101011 = 11
- Control decode: if sym is a control token, o_ctrl=token value, o_de=0, and o_data holds its previous value.
- Data decode, any other sym:
  - d = sym[9] ? ~sym[7:0] : sym[7:0]
  - o_data[0] = d[0]
  - for i in 1..7: o_data[i] = sym[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1])
  - o_de = o_locked (registered alongside o_data)
- Decoding runs in every FSM state; only o_de is gated by lock.
- FSM states: SEARCH, SLIP, LOCKED.
- SEARCH:
  - run counter: +1 on a control token, cleared on a non-control symbol.
  - timeout counter: +1 every cycle.
  - When run reaches CTRL_RUN: go to LOCKED; o_locked rises the next cycle.
  - Else, when timeout reaches SEARCH_TIMEOUT-1: pulse o_bitslip for 1 cycle and go to SLIP.
  - If lock and timeout occur in the same cycle, lock wins and no slip is issued.
- SLIP:
  - Wait counter counts SLIP_WAIT cycles; inputs are ignored for alignment.
  - Then clear run, timeout and wait counters and return to SEARCH.
  - o_bitslip is never asserted outside the single SEARCH→SLIP transition cycle.
- LOCKED:
  - o_locked=1.
  - loss counter cleared on any control token, else +1.
  - When loss reaches LOSS_TIMEOUT-1: go to SEARCH with counters cleared; o_locked falls the next cycle.
- Counter widths are $clog2(param+1); all counters saturate and never wrap.
- Reset asserted mid-operation (including during SLIP or an o_bitslip pulse) clears everything immediately; a slip pulse is never extended.

Decomposition:
- Shared header tmds_defs.vh holds the four control-token constants, reused with tmds_encoder_dvi so both ends agree.
- Sub-module tmds_word_align holds the SEARCH/SLIP/LOCKED FSM and its counters. Its interface is is_ctrl in; bitslip and locked out.
- The top level holds the 2-stage decode pipeline.

Test Plan:
- Reset: hold i_rst_n=0 with arbitrary i_tmds → all outputs 0; release → still 0 until tokens arrive.
- Aligned lock: 8 × 1101010100 → o_locked rises on cycle 10 after the first token (stage-1 delay + 8 + 1); o_ctrl=00 two cycles after the first token; no o_bitslip.
- Data decode while locked:
  - 0100000000 → o_data=0x00, o_de=1 two cycles later.
  - 1011111111 → o_data=0xFE.
  - 0010101011 → o_de=0, o_ctrl=01.
- Misalignment (SEARCH_TIMEOUT=32, SLIP_WAIT=4): bench model rotates control tokens by 3 bits and rotates back one bit per o_bitslip → exactly 3 one-cycle pulses, 36 cycles apart (32 + 4), then o_locked=1.
- Lock loss (LOSS_TIMEOUT=64): after lock, send only data symbols → o_locked falls after 64 cycles, o_de=0 thereafter; resume tokens → relock.
- Async reset while locked: drop i_rst_n mid-data → o_locked/o_de/o_data clear without waiting for a clock edge.

Source files
------------

// File: rtl/tmds_decoder_dvi_pkg.sv
// rtl/tmds_decoder_dvi_pkg.sv - TMDS control tokens, alignment states and symbol decode helper
package tmds_decoder_dvi_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ALIGN_SEARCH,
    ALIGN_SLIP,
    ALIGN_LOCKED
  } align_state_t;

  typedef struct packed {
    logic       is_ctrl;
    logic [1:0] ctrl;
    logic [7:0] data;
  } tmds_sym_t;

  // Data and control interpretations are both produced; the caller picks by is_ctrl.
  function automatic tmds_sym_t tmds_decode(input logic [9:0] sym);
    tmds_sym_t  r;
    logic [7:0] d;
    r = '0;
    d = sym[9] ? ~sym[7:0] : sym[7:0];
    r.data[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      r.data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    case (sym)
      CTRL_TOKEN_00: begin r.is_ctrl = 1'b1; r.ctrl = 2'b00; end
      CTRL_TOKEN_01: begin r.is_ctrl = 1'b1; r.ctrl = 2'b01; end
      CTRL_TOKEN_10: begin r.is_ctrl = 1'b1; r.ctrl = 2'b10; end
      CTRL_TOKEN_11: begin r.is_ctrl = 1'b1; r.ctrl = 2'b11; end
      default:       r.is_ctrl = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tmds_word_align.sv
// rtl/tmds_word_align.sv - character alignment FSM: hunts control-token runs, requests bit-slips
module tmds_word_align
  import tmds_decoder_dvi_pkg::*;
#(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int SLIP_WAIT      = 16,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic is_ctrl,
  output logic bitslip,
  output logic locked
);

  localparam int RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int TMO_W  = $clog2(SEARCH_TIMEOUT + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
  localparam int LOSS_W = $clog2(LOSS_TIMEOUT + 1);

  localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(CTRL_RUN);
  localparam logic [TMO_W-1:0]  TMO_SLIP  = TMO_W'(SEARCH_TIMEOUT - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(SEARCH_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(SLIP_WAIT);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);
  localparam logic [LOSS_W-1:0] LOSS_MAX  = LOSS_W'(LOSS_TIMEOUT);

  align_state_t      state;
  logic [RUN_W-1:0]  run;
  logic [TMO_W-1:0]  tmo;
  logic [WAIT_W-1:0] wait_cnt;
  logic [LOSS_W-1:0] loss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ALIGN_SEARCH;
      run      <= '0;
      tmo      <= '0;
      wait_cnt <= '0;
      loss     <= '0;
      bitslip  <= 1'b0;
      locked   <= 1'b0;
    end else begin
      bitslip <= 1'b0;
      case (state)
        ALIGN_SEARCH: begin
          // Lock is tested first so a simultaneous timeout never slips an aligned stream.
          if (run == RUN_LOCK) begin
            state  <= ALIGN_LOCKED;
            locked <= 1'b1;
            run    <= '0;
            tmo    <= '0;
            loss   <= '0;
          end else if (tmo == TMO_SLIP) begin
            state    <= ALIGN_SLIP;
            bitslip  <= 1'b1;
            wait_cnt <= '0;
          end else begin
            if (!is_ctrl)             run <= '0;
            else if (run != RUN_LOCK) run <= run + 1'b1;
            if (tmo != TMO_MAX) tmo <= tmo + 1'b1;
          end
        end
        ALIGN_SLIP: begin
          if (wait_cnt == WAIT_LAST) begin
            state    <= ALIGN_SEARCH;
            run      <= '0;
            tmo      <= '0;
            wait_cnt <= '0;
          end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ALIGN_LOCKED: begin
          if (loss == LOSS_LAST) begin
            state  <= ALIGN_SEARCH;
            locked <= 1'b0;
            run    <= '0;
            tmo    <= '0;
            loss   <= '0;
          end else if (is_ctrl) begin
            loss <= '0;
          end else if (loss != LOSS_MAX) begin
            loss <= loss + 1'b1;
          end
        end
        default: begin
          state  <= ALIGN_SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tmds_decoder_dvi.sv
// rtl/tmds_decoder_dvi.sv - one-channel DVI TMDS receiver: word alignment plus 2-stage decode
module tmds_decoder_dvi
  import tmds_decoder_dvi_pkg::*;
#(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int SLIP_WAIT      = 16,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_tmds,
  output logic       o_bitslip,
  output logic       o_locked,
  output logic       o_de,
  output logic [7:0] o_data,
  output logic [1:0] o_ctrl
);

  logic [9:0] sym;
  logic       sym_vld;
  tmds_sym_t  dec;

  // sym_vld keeps the reset value of sym from being decoded or counted as a symbol.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sym     <= '0;
      sym_vld <= 1'b0;
    end else begin
      sym     <= i_tmds;
      sym_vld <= 1'b1;
    end
  end

  assign dec = tmds_decode(sym);

  tmds_word_align #(
    .CTRL_RUN      (CTRL_RUN),
    .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
    .SLIP_WAIT     (SLIP_WAIT),
    .LOSS_TIMEOUT  (LOSS_TIMEOUT)
  ) u_align (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .is_ctrl(sym_vld & dec.is_ctrl),
    .bitslip(o_bitslip),
    .locked (o_locked)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_de   <= 1'b0;
      o_data <= '0;
      o_ctrl <= '0;
    end else if (sym_vld) begin
      if (dec.is_ctrl) begin
        o_ctrl <= dec.ctrl;
        o_de   <= 1'b0;
      end else begin
        o_data <= dec.data;
        o_de   <= o_locked;
      end
    end
  end

endmodule

// File: tb/tb_tmds_decoder_dvi.sv
// tb/tb_tmds_decoder_dvi.sv - self-checking bench for tmds_decoder_dvi
module tb_tmds_decoder_dvi;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] tmds = '0;
  logic       o_bitslip, o_locked, o_de;
  logic [7:0] o_data;
  logic [1:0] o_ctrl;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_data;
  logic [1:0] m_ctrl;

  tmds_decoder_dvi #(
    .CTRL_RUN(8), .SEARCH_TIMEOUT(32), .SLIP_WAIT(4), .LOSS_TIMEOUT(64)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_tmds   (tmds),
    .o_bitslip(o_bitslip),
    .o_locked (o_locked),
    .o_de     (o_de),
    .o_data   (o_data),
    .o_ctrl   (o_ctrl)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] rotr(input logic [9:0] w, input int k);
    logic [19:0] ww;
    ww = {w, w};
    return ww[k +: 10];
  endfunction

  // Reference model: word enters, expected stage-2 outputs are queued.
  task automatic model_push(input logic [9:0] w, input logic locked_now);
    exp_t       e;
    logic [7:0] d;
    logic       tok;
    tok = 1'b1;
    case (w)
      T00: m_ctrl = 2'b00;
      T01: m_ctrl = 2'b01;
      T10: m_ctrl = 2'b10;
      T11: m_ctrl = 2'b11;
      default: tok = 1'b0;
    endcase
    if (!tok) begin
      d = w[9] ? ~w[7:0] : w[7:0];
      m_data[0] = d[0];
      for (int i = 1; i < 8; i++) m_data[i] = d[i] ^ d[i-1] ^ ~w[8];
    end
    e.de   = locked_now & ~tok;
    e.data = m_data;
    e.ctrl = m_ctrl;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic lock_up(input string tag);
    tmds = T00;
    for (int c = 0; c < 60 && !o_locked; c++) @(negedge clk);
    n_vec++;
    if (o_locked !== 1'b1) begin
      n_err++;
      $display("FAIL %s_lock: o_locked=%b required 1 within 60 cycles", tag, o_locked);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tmds = 10'($urandom);
      @(negedge clk);
      n_vec++;
      if ({o_bitslip, o_locked, o_de, o_data, o_ctrl} !== 13'd0) begin
        n_err++;
        $display("FAIL reset_hold: outputs=%h required 0", {o_bitslip, o_locked, o_de, o_data, o_ctrl});
      end
    end
    rst_n = 1'b1;
    tmds  = 10'b0000000000;
    @(negedge clk);
    n_vec++;
    if ({o_bitslip, o_locked, o_de, o_data, o_ctrl} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_release: outputs=%h required 0", {o_bitslip, o_locked, o_de, o_data, o_ctrl});
    end
  endtask

  task automatic test_aligned_lock();
    int slips;
    slips = 0;
    do_reset();
    tmds = T00;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (o_bitslip) slips++;
      if (c == 2) begin
        n_vec++;
        if (o_ctrl !== 2'b00 || o_de !== 1'b0) begin
          n_err++;
          $display("FAIL lock_ctrl: o_ctrl=%b o_de=%b required 00/0", o_ctrl, o_de);
        end
      end
      if (c == 9 || c == 10) begin
        n_vec++;
        if (o_locked !== (c == 10)) begin
          n_err++;
          $display("FAIL lock_cycle%0d: o_locked=%b required %b", c, o_locked, c == 10);
        end
      end
    end
    n_vec++;
    if (slips != 0) begin
      n_err++;
      $display("FAIL lock_noslip: bitslip pulses=%0d required 0", slips);
    end
  endtask

  task automatic test_decode();
    logic [9:0] vec[$];
    exp_t       e;
    do_reset();
    lock_up("decode");
    m_data = 8'h00;
    m_ctrl = 2'b00;
    sb.delete();
    vec = '{10'b0100000000, 10'b1011111111, T01, 10'b0111110000, T10,
            10'b1000001111, T11, 10'b0110011001, T00};
    repeat (6) vec.push_back(10'($urandom));
    for (int k = 0; k < vec.size() + 2; k++) begin
      if (k >= 2) begin
        e = sb.pop_front();
        n_vec++;
        if (o_de !== e.de || o_data !== e.data || o_ctrl !== e.ctrl) begin
          n_err++;
          $display("FAIL decode[%0d] in=%b: de/data/ctrl=%b/%h/%b required %b/%h/%b",
                   k - 2, vec[k-2], o_de, o_data, o_ctrl, e.de, e.data, e.ctrl);
        end
      end
      if (k < vec.size()) begin
        tmds = vec[k];
        model_push(vec[k], 1'b1);
      end else begin
        tmds = T00;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_misalign();
    int off;
    int pulses[$];
    off  = 3;
    tmds = rotr(T00, off);
    do_reset();
    for (int c = 1; c <= 300 && !o_locked; c++) begin
      @(negedge clk);
      if (o_bitslip) begin
        pulses.push_back(c);
        if (off > 0) off--;
      end
      tmds = rotr(T00, off);
    end
    n_vec++;
    if (pulses.size() != 3) begin
      n_err++;
      $display("FAIL slip_count: pulses=%0d required 3", pulses.size());
    end
    if (pulses.size() >= 1) begin
      n_vec++;
      if (pulses[0] != 32) begin
        n_err++;
        $display("FAIL slip_first: cycle=%0d required 32", pulses[0]);
      end
    end
    for (int i = 1; i < pulses.size(); i++) begin
      n_vec++;
      if (pulses[i] - pulses[i-1] != 36) begin
        n_err++;
        $display("FAIL slip_gap%0d: gap=%0d required 36", i, pulses[i] - pulses[i-1]);
      end
    end
    n_vec++;
    if (o_locked !== 1'b1) begin
      n_err++;
      $display("FAIL slip_relock: o_locked=%b required 1", o_locked);
    end
  endtask

  task automatic test_lock_loss();
    int c;
    do_reset();
    lock_up("loss_pre");
    tmds = 10'b0100000000;
    c = 0;
    while (o_locked && c < 200) begin
      @(negedge clk);
      c++;
    end
    n_vec++;
    if (c != 65) begin
      n_err++;
      $display("FAIL loss_time: o_locked fell after %0d cycles required 65", c);
    end
    @(negedge clk);
    n_vec++;
    if (o_de !== 1'b0) begin
      n_err++;
      $display("FAIL loss_de: o_de=%b required 0", o_de);
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if (o_de !== 1'b0 || o_locked !== 1'b0) begin
      n_err++;
      $display("FAIL loss_hold: o_de=%b o_locked=%b required 0/0", o_de, o_locked);
    end
    lock_up("relock");
  endtask

  task automatic test_async_reset();
    do_reset();
    lock_up("async_pre");
    tmds = 10'b1011111111;
    repeat (3) @(negedge clk);
    n_vec++;
    if (o_data !== 8'hFE || o_de !== 1'b1) begin
      n_err++;
      $display("FAIL async_pre_data: o_data=%h o_de=%b required fe/1", o_data, o_de);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (o_locked !== 1'b0 || o_de !== 1'b0 || o_data !== 8'h00 || o_bitslip !== 1'b0) begin
      n_err++;
      $display("FAIL async_clear: locked/de/data/slip=%b/%b/%h/%b required 0/0/00/0",
               o_locked, o_de, o_data, o_bitslip);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_aligned_lock();
    test_decode();
    test_misalign();
    test_lock_loss();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
